// File: rtl/alu_seq_if.sv
// Handshake bus for alu_seq: operation request channel (in_*, A, B, cntrl,
// set_flags) and result channel (out_*, result, flags, architectural nzcv).
// master = producer of operations / consumer of results, slave = the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       cntrl;
  logic             set_flags;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             negative;
  logic             zero;
  logic             overflow;
  logic             carry_out;
  logic [3:0]       nzcv;

  modport master (
    output in_valid, A, B, cntrl, set_flags, out_ready,
    input  in_ready, out_valid, result, negative, zero, overflow, carry_out, nzcv
  );

  modport slave (
    input  in_valid, A, B, cntrl, set_flags, out_ready,
    output in_ready, out_valid, result, negative, zero, overflow, carry_out, nzcv
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered EX-stage ALU with valid/ready handshakes and an
// architectural NZCV register.
// Ops (cntrl): 000 pass B, 001 LSL, 010 ADD, 011 SUB, 100 AND, 101 OR,
// 110 XOR, 111 MUL.
// Build option: define ALU_MUL_EN to get the iterative shift-add multiplier
// (WIDTH steps, IDLE -> MUL -> DONE). Without it, op 111 finishes in one
// cycle with result 0 and no multiplier hardware is built.
// WIDTH must be a power of two and at least 8.
module alu_seq #(
  parameter int WIDTH = 64
) (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_DONE = 2'b10;
`ifdef ALU_MUL_EN
  localparam logic [1:0] ST_MUL  = 2'b01;
  localparam logic [SHW-1:0] MUL_LAST = SHW'(WIDTH - 1);
`endif

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_LSL  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [WIDTH-1:0] result_reg;
  logic             neg_reg;
  logic             zero_reg;
  logic             carry_reg;
  logic             ovf_reg;
  logic             sf_reg;
  logic [3:0]       nzcv_reg;

  logic             in_ready_int;
  logic             out_valid_int;
  logic             accept;
  logic             handshake;
  logic             load_alu;

  // ---------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------

  // Logarithmic left shifter: stage gi conditionally shifts by 2**gi.
  // Only B[SHW-1:0] steer the stages, so upper B bits never affect LSL.
  logic [SHW:0][WIDTH-1:0] shl_stage;
  assign shl_stage[0] = bus.A;

  genvar gi;
  generate
    for (gi = 0; gi < SHW; gi++) begin : g_shl
      localparam int SH = 1 << gi;
      assign shl_stage[gi+1] = bus.B[gi]
                             ? {shl_stage[gi][WIDTH-SH-1:0], {SH{1'b0}}}
                             : shl_stage[gi];
    end
  endgenerate

  logic             is_sub;
  logic             is_addsub;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] alu_result;
  logic             alu_neg;
  logic             alu_zero;
  logic             alu_carry;
  logic             alu_ovf;

  // Shared adder: SUB is A + ~B + 1, so carry_out = 1 means no borrow.
  always_comb begin
    is_sub    = (bus.cntrl == OP_SUB);
    is_addsub = (bus.cntrl == OP_ADD) || is_sub;
    add_b     = is_sub ? ~bus.B : bus.B;
    add_sum   = {1'b0, bus.A} + {1'b0, add_b} + {{WIDTH{1'b0}}, is_sub};
  end

  // Operation select and flag generation for the one-cycle ops.
  always_comb begin
    alu_result = '0;
    case (bus.cntrl)
      OP_PASS: alu_result = bus.B;
      OP_LSL:  alu_result = shl_stage[SHW];
      OP_ADD:  alu_result = add_sum[WIDTH-1:0];
      OP_SUB:  alu_result = add_sum[WIDTH-1:0];
      OP_AND:  alu_result = bus.A & bus.B;
      OP_OR:   alu_result = bus.A | bus.B;
      OP_XOR:  alu_result = bus.A ^ bus.B;
      OP_MUL:  alu_result = '0;
      default: alu_result = '0;
    endcase
    alu_neg   = alu_result[WIDTH-1];
    alu_zero  = (alu_result == '0);
    alu_carry = is_addsub & add_sum[WIDTH];
    // Signed overflow: both addends share a sign that the sum does not.
    alu_ovf   = is_addsub & (bus.A[WIDTH-1] == add_b[WIDTH-1])
                          & (add_sum[WIDTH-1] != bus.A[WIDTH-1]);
  end

  // ---------------------------------------------------------------------
  // Handshake control
  // ---------------------------------------------------------------------

  // DONE forwards out_ready to in_ready so a retiring result and a new op
  // can cross in the same cycle.
  always_comb begin
    in_ready_int  = (state_reg == ST_IDLE) ||
                    ((state_reg == ST_DONE) && bus.out_ready);
    out_valid_int = (state_reg == ST_DONE);
    accept        = bus.in_valid && in_ready_int;
    handshake     = out_valid_int && bus.out_ready;
  end

`ifdef ALU_MUL_EN
  // ---------------------------------------------------------------------
  // Iterative shift-add multiplier
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] mul_a_reg;
  logic [WIDTH-1:0] mul_b_reg;
  logic [WIDTH-1:0] mul_acc_reg;
  logic [SHW-1:0]   mul_cnt_reg;
  logic [WIDTH-1:0] mul_acc_next;
  logic             mul_start;
  logic             mul_last;

  // One multiplier bit per step; the multiplicand shifts left in lockstep.
  always_comb begin
    mul_start    = accept && (bus.cntrl == OP_MUL);
    mul_last     = (state_reg == ST_MUL) && (mul_cnt_reg == MUL_LAST);
    mul_acc_next = mul_acc_reg + (mul_b_reg[0] ? mul_a_reg : '0);
  end

  // Operands are latched once at accept and never re-sampled during MUL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_a_reg   <= '0;
      mul_b_reg   <= '0;
      mul_acc_reg <= '0;
      mul_cnt_reg <= '0;
    end else if (mul_start) begin
      mul_a_reg   <= bus.A;
      mul_b_reg   <= bus.B;
      mul_acc_reg <= '0;
      mul_cnt_reg <= '0;
    end else if (state_reg == ST_MUL) begin
      mul_a_reg   <= mul_a_reg << 1;
      mul_b_reg   <= mul_b_reg >> 1;
      mul_acc_reg <= mul_acc_next;
      mul_cnt_reg <= mul_cnt_reg + 1'b1;
    end
  end
`endif

  // Next-state selection for IDLE / MUL / DONE.
  always_comb begin
    state_next = state_reg;
    load_alu   = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
`ifdef ALU_MUL_EN
          if (bus.cntrl == OP_MUL) begin
            state_next = ST_MUL;
          end else begin
            state_next = ST_DONE;
            load_alu   = 1'b1;
          end
`else
          state_next = ST_DONE;
          load_alu   = 1'b1;
`endif
        end else if (handshake) begin
          state_next = ST_IDLE;
        end
      end
`ifdef ALU_MUL_EN
      ST_MUL: begin
        if (mul_last) begin
          state_next = ST_DONE;
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // State register; reset aborts any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Result and flag registers: load on a one-cycle accept or on the final
  // multiply step, otherwise hold (this is what keeps DONE stable on stall).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_reg <= '0;
      neg_reg    <= 1'b0;
      zero_reg   <= 1'b0;
      carry_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
    end else if (load_alu) begin
      result_reg <= alu_result;
      neg_reg    <= alu_neg;
      zero_reg   <= alu_zero;
      carry_reg  <= alu_carry;
      ovf_reg    <= alu_ovf;
    end
`ifdef ALU_MUL_EN
    else if (mul_last) begin
      result_reg <= mul_acc_next;
      neg_reg    <= mul_acc_next[WIDTH-1];
      zero_reg   <= (mul_acc_next == '0);
      carry_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
    end
`endif
  end

  // set_flags travels with the accepted op until its result retires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sf_reg <= 1'b0;
    end else if (accept) begin
      sf_reg <= bus.set_flags;
    end
  end

  // Architectural NZCV commits only when a flag-setting result handshakes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nzcv_reg <= 4'b0000;
    end else if (handshake && sf_reg) begin
      nzcv_reg <= {neg_reg, zero_reg, carry_reg, ovf_reg};
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_int;
  assign bus.result    = result_reg;
  assign bus.negative  = neg_reg;
  assign bus.zero      = zero_reg;
  assign bus.carry_out = carry_reg;
  assign bus.overflow  = ovf_reg;
  assign bus.nzcv      = nzcv_reg;

endmodule
